seg7_display_reader: RTL and testbench
======================================

// Module: seg7_display_reader
// PURPOSE
//   Receive-side monitor for the 7-segment display bus driven by final_block. Samples
//   the 7-bit segment pattern, filters glitches with a stability window and decodes
//   accepted patterns back to a hex digit. Optionally checks that successive digits
//   count up modulo SEQ_MOD. Used on-chip as a loopback self-check (segments fed
//   back via uio_in) and as the bench-side decoder for display tests.
// PARAMETERS
//   STABLE_CYCLES  4   consecutive identical samples needed to accept a pattern (>=1)
//   CNT_W          8   width of accept_cnt / seq_err_cnt (saturating)
//   SEQ_MOD        10  modulus of the expected count-up sequence (2..16)
// PORTS
//   clk          in   1      single clock, rising edge
//   rst          in   1      synchronous, active-high reset
//   sample_en    in   1      sample strike (e.g. divided-clock tick); 1-cycle pulse or level
//   seg_in       in   7      segments, bit0=a .. bit6=g, active-high
//   digit        out  4      last accepted decoded digit 0x0-0xF
//   digit_valid  out  1      1-cycle pulse: new digit accepted
//   blank        out  1      level: last accepted pattern was 7'h00
//   bad_code     out  1      1-cycle pulse: accepted pattern is neither blank nor a hex glyph
//   accept_cnt   out  CNT_W  count of digit_valid pulses, saturates at all-ones
//   seq_err      out  1      sticky: sequence break seen (SEQ_CHECK_EN only)
//   seq_err_cnt  out  CNT_W  sequence breaks, saturating (SEQ_CHECK_EN only)
// BEHAVIOUR
//   Reset: all outputs 0; cand=0, stab_cnt=0, last accepted=none; FSM->WAIT_FIRST.
//   rst dominates sample_en in the same cycle.
//   Glyph table (seg_in -> digit): 3F:0 06:1 5B:2 4F:3 66:4 6D:5 7D:6 07:7 7F:8 6F:9
//     77:A 7C:b 39:C 5E:d 79:E 71:F. 00 = blank. Anything else = bad code.
//   Only cycles with sample_en=1 advance the filter; otherwise all state holds and
//   digit_valid/bad_code are 0.
//   Filter, per sample: if seg_in != cand -> cand<=seg_in, stab_cnt<=1, FSM->SETTLING;
//     else if stab_cnt<STABLE_CYCLES -> stab_cnt++; stab_cnt saturates at STABLE_CYCLES.
//   Accept = the sample on which stab_cnt reaches STABLE_CYCLES. With STABLE_CYCLES=1,
//     the first sample of a new pattern accepts immediately.
//   FSM: WAIT_FIRST (nothing accepted yet) -> SETTLING on first sample;
//     SETTLING -> STABLE on accept; STABLE -> SETTLING on any pattern change.
//   On accept, registered outputs update on the next clk edge (1-cycle latency):
//     glyph: digit<=value, blank<=0, digit_valid=1, accept_cnt++ (saturating).
//     blank: blank<=1, digit holds, no digit_valid.
//     bad:   bad_code=1, digit and blank hold.
//   Accepting the same glyph again, after a glitch shorter than STABLE_CYCLES that
//     never accepted, gives no second pulse. A glyph re-accepted after an accepted
//     blank or bad code pulses again.
//   Sequence check (macro on): on each glyph accept with have_prev=1, if
//     digit_new != (prev+1) mod SEQ_MOD -> seq_err<=1, seq_err_cnt++ (saturating).
//     prev<=digit_new, have_prev<=1. An accepted blank or bad code clears have_prev.
//     Glyphs >= SEQ_MOD always count as breaks when have_prev=1.
// CONFIGURATION
//   SEG7_SEQ_CHECK_EN defined: sequence checker built as above.
//   Not defined: prev/have_prev/err logic absent; seq_err and seq_err_cnt tied to 0.
//   Filter and decode are identical in both builds.
// TESTING
//   Reset, hold seg_in=3F, sample_en=1 for 4 cycles -> digit_valid pulses once on the
//     cycle after the 4th sample, digit=0, accept_cnt=1.
//   Stable 06, then a 2-sample glitch to 7F, then 06 again -> exactly one digit_valid
//     (digit=1); no accept of 8.
//   Send 3F,06,5B,4F, each stable 4 samples, with SEQ_CHECK_EN -> 4 pulses, digits
//     0,1,2,3, seq_err=0.
//   6F(9) then 3F(0) -> no error; 9 then 5B(2) -> seq_err=1, seq_err_cnt=1, sticky.
//   Pattern 0x2A stable -> bad_code pulse, digit unchanged; then 00 -> blank=1; then
//     06 -> digit_valid, no seq error (chain cleared).
//   Assert rst while in SETTLING with stab_cnt=3 -> all outputs 0 next cycle; then 3F
//     needs a full 4 samples to accept. Repeat with sample_en gated every 3rd cycle:
//     accept lands on the 4th strobe.

Source files
------------

// File: rtl/seg7_display_reader.sv
// seg7_display_reader: receive-side monitor for a 7-segment display bus.
// It samples seg_in on sample_en strobes and uses a stability window to reject
// glitches. Accepted patterns are decoded back to a hex digit.
//
// Optional macro SEG7_SEQ_CHECK_EN builds a checker. The checker flags any
// accepted digit that does not follow (prev+1) mod SEQ_MOD. Without the macro,
// seq_err and seq_err_cnt are tied to 0.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   sample_en    in   sample strobe; cycles without it hold all state
//   seg_in       in   [6:0] segments, bit0=a .. bit6=g, active-high
//   digit        out  [3:0] last accepted decoded digit
//   digit_valid  out  1-cycle pulse on a newly accepted glyph
//   blank        out  level, last accepted pattern was all-off
//   bad_code     out  1-cycle pulse on an accepted non-glyph, non-blank pattern
//   accept_cnt   out  [CNT_W-1:0] saturating count of digit_valid pulses
//   seq_err      out  sticky sequence-break flag
//   seq_err_cnt  out  [CNT_W-1:0] saturating count of sequence breaks
module seg7_display_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned SEQ_MOD       = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [6:0]       seg_in,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             blank,
    output logic             bad_code,
    output logic [CNT_W-1:0] accept_cnt,
    output logic             seq_err,
    output logic [CNT_W-1:0] seq_err_cnt
);

    localparam int unsigned     STAB_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_ACC = STAB_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1 || SEQ_MOD < 2 || SEQ_MOD > 16) begin : g_bad_param
        $error("seg7_display_reader: parameter out of range");
    end

    typedef enum logic [1:0] {WAIT_FIRST, SETTLING, STABLE} state_t;

    state_t              state, state_nxt;
    logic [6:0]          cand, cand_nxt;
    logic [STAB_W-1:0]   stab_cnt, stab_nxt;
    logic                have_last, have_last_nxt;
    logic [6:0]          last_pat, last_pat_nxt;
    logic [3:0]          digit_nxt;
    logic                digit_valid_nxt, blank_nxt, bad_code_nxt;
    logic [CNT_W-1:0]    accept_cnt_nxt;
    logic                accept, accept_new;
    logic [4:0]          dec;

    // Glyph decode: {is_glyph, value}
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F: decode = {1'b1, 4'h0};
            7'h06: decode = {1'b1, 4'h1};
            7'h5B: decode = {1'b1, 4'h2};
            7'h4F: decode = {1'b1, 4'h3};
            7'h66: decode = {1'b1, 4'h4};
            7'h6D: decode = {1'b1, 4'h5};
            7'h7D: decode = {1'b1, 4'h6};
            7'h07: decode = {1'b1, 4'h7};
            7'h7F: decode = {1'b1, 4'h8};
            7'h6F: decode = {1'b1, 4'h9};
            7'h77: decode = {1'b1, 4'hA};
            7'h7C: decode = {1'b1, 4'hB};
            7'h39: decode = {1'b1, 4'hC};
            7'h5E: decode = {1'b1, 4'hD};
            7'h79: decode = {1'b1, 4'hE};
            7'h71: decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    assign dec = decode(seg_in);

    // Filter, FSM next state and output next values
    always_comb begin
        state_nxt       = state;
        cand_nxt        = cand;
        stab_nxt        = stab_cnt;
        have_last_nxt   = have_last;
        last_pat_nxt    = last_pat;
        digit_nxt       = digit;
        blank_nxt       = blank;
        accept_cnt_nxt  = accept_cnt;
        digit_valid_nxt = 1'b0;
        bad_code_nxt    = 1'b0;
        accept          = 1'b0;
        accept_new      = 1'b0;

        if (sample_en) begin
            if (seg_in != cand) begin
                cand_nxt  = seg_in;
                stab_nxt  = STAB_W'(1);
                state_nxt = SETTLING;
                accept    = (STABLE_CYCLES == 1);
            end else if (stab_cnt < STAB_MAX) begin
                stab_nxt = STAB_W'(stab_cnt + 1'b1);
                accept   = (stab_cnt == STAB_ACC);
            end
            if (state == WAIT_FIRST) state_nxt = SETTLING;
            if (accept) state_nxt = STABLE;
        end

        // Re-accepting the pattern already reported (after an unaccepted glitch) is silent
        accept_new = accept && (!have_last || seg_in != last_pat);

        if (accept_new) begin
            have_last_nxt = 1'b1;
            last_pat_nxt  = seg_in;
            if (dec[4]) begin
                digit_nxt       = dec[3:0];
                blank_nxt       = 1'b0;
                digit_valid_nxt = 1'b1;
                if (accept_cnt != {CNT_W{1'b1}})
                    accept_cnt_nxt = CNT_W'(accept_cnt + 1'b1);
            end else if (seg_in == 7'h00) begin
                blank_nxt = 1'b1;
            end else begin
                bad_code_nxt = 1'b1;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_FIRST;
            cand        <= 7'h00;
            stab_cnt    <= '0;
            have_last   <= 1'b0;
            last_pat    <= 7'h00;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
            blank       <= 1'b0;
            bad_code    <= 1'b0;
            accept_cnt  <= '0;
        end else begin
            state       <= state_nxt;
            cand        <= cand_nxt;
            stab_cnt    <= stab_nxt;
            have_last   <= have_last_nxt;
            last_pat    <= last_pat_nxt;
            digit       <= digit_nxt;
            digit_valid <= digit_valid_nxt;
            blank       <= blank_nxt;
            bad_code    <= bad_code_nxt;
            accept_cnt  <= accept_cnt_nxt;
        end
    end

`ifdef SEG7_SEQ_CHECK_EN
    logic [3:0]       prev, prev_nxt, next_exp;
    logic             have_prev, have_prev_nxt;
    logic             seq_err_nxt;
    logic [CNT_W-1:0] seq_err_cnt_nxt;
    logic             glyph_ev, clear_ev;

    assign glyph_ev = accept_new && dec[4];
    assign clear_ev = accept_new && !dec[4];
    assign next_exp = 4'((5'(prev) + 5'd1) % 5'(SEQ_MOD));

    // Count-up checker; blank or bad code breaks the chain
    always_comb begin
        prev_nxt        = prev;
        have_prev_nxt   = have_prev;
        seq_err_nxt     = seq_err;
        seq_err_cnt_nxt = seq_err_cnt;
        if (glyph_ev) begin
            if (have_prev && dec[3:0] != next_exp) begin
                seq_err_nxt = 1'b1;
                if (seq_err_cnt != {CNT_W{1'b1}})
                    seq_err_cnt_nxt = CNT_W'(seq_err_cnt + 1'b1);
            end
            prev_nxt      = dec[3:0];
            have_prev_nxt = 1'b1;
        end else if (clear_ev) begin
            have_prev_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev        <= 4'h0;
            have_prev   <= 1'b0;
            seq_err     <= 1'b0;
            seq_err_cnt <= '0;
        end else begin
            prev        <= prev_nxt;
            have_prev   <= have_prev_nxt;
            seq_err     <= seq_err_nxt;
            seq_err_cnt <= seq_err_cnt_nxt;
        end
    end
`else
    assign seq_err     = 1'b0;
    assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_seg7_display_reader.sv
// Directed bench for seg7_display_reader with a pulse scoreboard.
module tb_seg7_display_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_en;
    logic [6:0] seg_in;
    logic [3:0] digit;
    logic       digit_valid, blank, bad_code, seq_err;
    logic [7:0] accept_cnt, seq_err_cnt;

`ifdef SEG7_SEQ_CHECK_EN
    localparam int unsigned SEQ_ON = 1;
`else
    localparam int unsigned SEQ_ON = 0;
`endif

    seg7_display_reader dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .seg_in(seg_in),
        .digit(digit), .digit_valid(digit_valid), .blank(blank), .bad_code(bad_code),
        .accept_cnt(accept_cnt), .seq_err(seq_err), .seq_err_cnt(seq_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       is_bad;
        logic [3:0] dig;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_err  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive, let the edge pass, then check pulses against the scoreboard
    task automatic tick(input logic [6:0] s, input logic en);
        exp_t e;
        seg_in    = s;
        sample_en = en;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() != 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            chk("pulse_kind", 32'({digit_valid, bad_code}), e.is_bad ? 32'd1 : 32'd2);
            if (!e.is_bad) chk("pulse_digit", 32'(digit), 32'(e.dig));
        end else begin
            chk("no_pulse", 32'({digit_valid, bad_code}), 32'd0);
        end
    endtask

    // n samples of pat, each followed by gap unstrobed cycles carrying junk;
    // acc = 1-based sample that should report (0 = none)
    task automatic hold(input logic [6:0] pat, input int n, input int acc,
                        input logic is_bad, input logic [3:0] dig, input int gap);
        if (acc != 0) sb.push_back('{cyc + (acc - 1) * (gap + 1) + 1, is_bad, dig});
        for (int k = 0; k < n; k++) begin
            tick(pat, 1'b1);
            for (int g = 0; g < gap; g++) tick(7'h2A, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(7'h3F, 1'b1);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_digit"}, 32'(digit), 32'd0);
        chk({tag, "_blank"}, 32'(blank), 32'd0);
        chk({tag, "_acnt"}, 32'(accept_cnt), 32'd0);
        chk({tag, "_serr"}, 32'(seq_err), 32'd0);
        chk({tag, "_secnt"}, 32'(seq_err_cnt), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        sample_en = 1'b0;
        seg_in    = 7'h00;
        tick(7'h3F, 1'b1);
        tick(7'h3F, 1'b1);
        chk_zero("reset");
        rst = 1'b0;

        // First accept after 4 samples of 0
        hold(7'h3F, 4, 4, 1'b0, 4'h0, 0);
        chk("first_acnt", 32'(accept_cnt), 32'd1);
        tick(7'h3F, 1'b0);

        // Glitch to 8 shorter than the window, then back to 1: one pulse only
        hold(7'h06, 4, 4, 1'b0, 4'h1, 0);
        hold(7'h7F, 2, 0, 1'b0, 4'h0, 0);
        hold(7'h06, 4, 0, 1'b0, 4'h0, 0);
        chk("glitch_digit", 32'(digit), 32'd1);
        chk("glitch_acnt", 32'(accept_cnt), 32'd2);

        hold(7'h5B, 4, 4, 1'b0, 4'h2, 0);
        hold(7'h4F, 4, 4, 1'b0, 4'h3, 0);
        chk("run_acnt", 32'(accept_cnt), 32'd4);
        chk("run_serr", 32'(seq_err), 32'd0);

        // Blank, then 9 -> 0 wraps cleanly
        hold(7'h00, 4, 0, 1'b0, 4'h0, 0);
        chk("blank_set", 32'(blank), 32'd1);
        chk("blank_digit", 32'(digit), 32'd3);
        hold(7'h6F, 4, 4, 1'b0, 4'h9, 0);
        chk("blank_clr", 32'(blank), 32'd0);
        hold(7'h3F, 4, 4, 1'b0, 4'h0, 0);
        chk("wrap_serr", 32'(seq_err), 32'd0);
        chk("wrap_secnt", 32'(seq_err_cnt), 32'd0);

        // 9 -> 2 is a break; then 2 -> 3 keeps the flag sticky
        hold(7'h00, 4, 0, 1'b0, 4'h0, 0);
        hold(7'h6F, 4, 4, 1'b0, 4'h9, 0);
        hold(7'h5B, 4, 4, 1'b0, 4'h2, 0);
        chk("break_serr", 32'(seq_err), 32'(SEQ_ON));
        chk("break_secnt", 32'(seq_err_cnt), 32'(SEQ_ON));
        hold(7'h4F, 4, 4, 1'b0, 4'h3, 0);
        chk("sticky_serr", 32'(seq_err), 32'(SEQ_ON));
        chk("sticky_secnt", 32'(seq_err_cnt), 32'(SEQ_ON));

        // Bad code, blank, then 1 with the chain cleared
        hold(7'h2A, 4, 4, 1'b1, 4'h0, 0);
        chk("bad_digit", 32'(digit), 32'd3);
        chk("bad_blank", 32'(blank), 32'd0);
        hold(7'h00, 4, 0, 1'b0, 4'h0, 0);
        chk("bad_then_blank", 32'(blank), 32'd1);
        hold(7'h06, 4, 4, 1'b0, 4'h1, 0);
        chk("chain_secnt", 32'(seq_err_cnt), 32'(SEQ_ON));
        chk("chain_acnt", 32'(accept_cnt), 32'd10);

        // Reset with three samples already counted; 0 then needs a full window
        hold(7'h3F, 3, 0, 1'b0, 4'h0, 0);
        do_reset();
        chk_zero("midrst");
        hold(7'h3F, 3, 0, 1'b0, 4'h0, 0);
        hold(7'h3F, 1, 1, 1'b0, 4'h0, 0);
        chk("midrst_acnt", 32'(accept_cnt), 32'd1);

        // Strobe every 3rd cycle with junk between strobes
        do_reset();
        chk_zero("gated_rst");
        hold(7'h3F, 4, 4, 1'b0, 4'h0, 2);
        chk("gated_acnt", 32'(accept_cnt), 32'd1);
        chk("gated_digit", 32'(digit), 32'd0);

        tick(7'h3F, 1'b1);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
